// File: rtl/flopenrc_pipe_pkg.sv
// Shared defaults and helpers for the flopenrc pipeline.
// Holds the default constants and the occupancy-width function.
package flopenrc_pipe_pkg;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF = 3;
  localparam logic [63:0] RESET_VAL_DEF = 64'd0;

  // Bits needed to count 0..depth valid stages.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/flopenrc.sv
// One pipeline stage: enabled register with async reset and sync clear.
// Ports: clk, reset (async, active-low), en, clr, d[WIDTH], q[WIDTH].
module flopenrc #(
  parameter int unsigned WIDTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= RESET_VAL;
    end else if (clr) begin
      q_q <= RESET_VAL;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/flopenrc_pipe.sv
// DEPTH-stage enabled/clearable pipeline with per-stage valid tags.
// Ports: clk, reset (async, active-low), en, clr, d, d_valid -> q, q_valid, occupancy.
module flopenrc_pipe
  import flopenrc_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter logic [WIDTH-1:0] RESET_VAL = RESET_VAL_DEF[WIDTH-1:0]
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clr,
  input  logic [WIDTH-1:0]          d,
  input  logic                      d_valid,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [occ_w(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OW = occ_w(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] data_q;
  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0]            vld_q;
  logic [DEPTH-1:0]            vld_d;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign data_d[i] = d;
      assign vld_d[i]  = d_valid;
    end else begin : g_body
      assign data_d[i] = data_q[i-1];
      assign vld_d[i]  = vld_q[i-1];
    end

    flopenrc #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_data (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (clr),
      .d     (data_d[i]),
      .q     (data_q[i])
    );

    flopenrc #(
      .WIDTH     (1),
      .RESET_VAL (1'b0)
    ) u_vld (
      .clk   (clk),
      .reset (reset),
      .en    (en),
      .clr   (clr),
      .d     (vld_d[i]),
      .q     (vld_q[i])
    );
  end

  // Tracks popcount of vld_q incrementally: one tag enters, one leaves.
  logic [OW-1:0] occ_q;
  logic [OW-1:0] occ_d;

  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (en) begin
      unique case ({d_valid, vld_q[DEPTH-1]})
        2'b10:   occ_d = occ_q + OW'(1);
        2'b01:   occ_d = occ_q - OW'(1);
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign q         = data_q[DEPTH-1];
  assign q_valid   = vld_q[DEPTH-1];
  assign occupancy = occ_q;

endmodule

// File: tb/tb_flopenrc_pipe.sv
// Scoreboard bench for flopenrc_pipe (DEPTH=3 and DEPTH=1 builds).
// Directed vectors; expectations queued, monitor pops and compares.
module tb_flopenrc_pipe;

  logic        clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset;
  logic        en, clr, d_valid;
  logic [31:0] d;
  logic [31:0] q;
  logic        q_valid;
  logic [1:0]  occupancy;

  logic        en1, clr1, dv1;
  logic [31:0] d1;
  logic [31:0] q1;
  logic        qv1;
  logic [0:0]  occ1;

  flopenrc_pipe #(.WIDTH(32), .DEPTH(3), .RESET_VAL(32'd0)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .clr       (clr),
    .d         (d),
    .d_valid   (d_valid),
    .q         (q),
    .q_valid   (q_valid),
    .occupancy (occupancy)
  );

  flopenrc_pipe #(.WIDTH(32), .DEPTH(1), .RESET_VAL(32'd0)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .en        (en1),
    .clr       (clr1),
    .d         (d1),
    .d_valid   (dv1),
    .q         (q1),
    .q_valid   (qv1),
    .occupancy (occ1)
  );

  typedef struct {
    string       nm;
    bit          one;
    logic [31:0] q;
    logic        v;
    logic [1:0]  occ;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   n_vec = 0;
  int   n_bad = 0;

  always begin : mon
    exp_t        e;
    logic [31:0] aq;
    logic        av;
    logic [1:0]  ao;
    @(chk_ev);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      if (e.one) begin
        aq = q1; av = qv1; ao = {1'b0, occ1};
      end else begin
        aq = q; av = q_valid; ao = occupancy;
      end
      n_vec++;
      if (aq !== e.q || av !== e.v || ao !== e.occ) begin
        n_bad++;
        $display("FAIL %s: got q=%h v=%b occ=%0d, want q=%h v=%b occ=%0d",
                 e.nm, aq, av, ao, e.q, e.v, e.occ);
      end
    end
  end

  task automatic chk(input string nm, input bit one, input logic [31:0] eq,
                     input logic ev, input logic [1:0] eo);
    exp_t e;
    e.nm = nm; e.one = one; e.q = eq; e.v = ev; e.occ = eo;
    sb.push_back(e);
    ->chk_ev;
    #0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic e_, input logic c_, input logic [31:0] d_,
                     input logic v_);
    en = e_; clr = c_; d = d_; d_valid = v_;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0;
    drv(1'b0, 1'b0, 32'd94, 1'b1);
    en1 = 1'b0; clr1 = 1'b0; d1 = 32'd5; dv1 = 1'b1;
    #5;
    chk("reset_state", 0, 32'd0, 1'b0, 2'd0);
    chk("reset_state1", 1, 32'd0, 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;

    // en=0 holds after release, including across falling edges
    tick(); chk("hold_e1", 0, 32'd0, 1'b0, 2'd0);
    @(negedge clk); #1; chk("hold_fall1", 0, 32'd0, 1'b0, 2'd0);
    tick(); chk("hold_e2", 0, 32'd0, 1'b0, 2'd0);
    @(negedge clk); #1; chk("hold_fall2", 0, 32'd0, 1'b0, 2'd0);
    chk("d1_hold", 1, 32'd0, 1'b0, 2'd0);

    // fill
    drv(1'b1, 1'b0, 32'd94, 1'b1); tick(); chk("fill1", 0, 32'd0, 1'b0, 2'd1);
    drv(1'b1, 1'b0, 32'd95, 1'b1); tick(); chk("fill2", 0, 32'd0, 1'b0, 2'd2);
    drv(1'b1, 1'b0, 32'd96, 1'b1); tick(); chk("fill3", 0, 32'd94, 1'b1, 2'd3);
    @(negedge clk); #1; chk("fill3_fall", 0, 32'd94, 1'b1, 2'd3);

    // drain with invalid entries behind
    drv(1'b1, 1'b0, 32'd0, 1'b0); tick(); chk("drain1", 0, 32'd95, 1'b1, 2'd2);
    tick(); chk("drain2", 0, 32'd96, 1'b1, 2'd1);
    tick(); chk("drain3", 0, 32'd0, 1'b0, 2'd0);
    tick(); chk("drain_empty", 0, 32'd0, 1'b0, 2'd0);

    // refill then stall with toggling d
    drv(1'b1, 1'b0, 32'd94, 1'b1); tick();
    drv(1'b1, 1'b0, 32'd95, 1'b1); tick();
    drv(1'b1, 1'b0, 32'd96, 1'b1); tick(); chk("refill", 0, 32'd94, 1'b1, 2'd3);
    for (int i = 0; i < 4; i++) begin
      drv(1'b0, 1'b0, (i % 2) ? 32'h5555_5555 : 32'hAAAA_AAAA, i[0]);
      tick(); chk($sformatf("stall%0d", i), 0, 32'd94, 1'b1, 2'd3);
    end
    drv(1'b1, 1'b0, 32'd97, 1'b1); tick(); chk("resume", 0, 32'd95, 1'b1, 2'd3);

    // clear wins over enable; d of that edge is discarded
    drv(1'b1, 1'b1, 32'd123, 1'b1); tick(); chk("clr_en", 0, 32'd0, 1'b0, 2'd0);
    drv(1'b0, 1'b0, 32'd0, 1'b0); tick(); chk("clr_after", 0, 32'd0, 1'b0, 2'd0);
    drv(1'b1, 1'b0, 32'd0, 1'b0); tick(); tick();
    tick(); chk("clr_discard", 0, 32'd0, 1'b0, 2'd0);

    // async reset mid clk-high phase
    drv(1'b1, 1'b0, 32'd1, 1'b1); tick();
    drv(1'b1, 1'b0, 32'd2, 1'b1); tick();
    drv(1'b1, 1'b0, 32'd3, 1'b1); tick(); chk("pre_rst", 0, 32'd1, 1'b1, 2'd3);
    drv(1'b0, 1'b0, 32'd3, 1'b1);
    @(posedge clk); #5;
    reset = 1'b0;
    #1; chk("async_rst", 0, 32'd0, 1'b0, 2'd0);
    @(negedge clk); #1;
    reset = 1'b1;
    drv(1'b1, 1'b0, 32'd7, 1'b1); tick(); chk("post_rst1", 0, 32'd0, 1'b0, 2'd1);
    tick(); chk("post_rst2", 0, 32'd0, 1'b0, 2'd2);
    tick(); chk("post_rst3", 0, 32'd7, 1'b1, 2'd3);

    // DEPTH=1 build
    en1 = 1'b1; clr1 = 1'b0; d1 = 32'hFFFF_FFFF; dv1 = 1'b1;
    tick(); chk("d1_load", 1, 32'hFFFF_FFFF, 1'b1, 2'd1);
    en1 = 1'b0; d1 = 32'h1234_5678; dv1 = 1'b0;
    tick(); chk("d1_stall", 1, 32'hFFFF_FFFF, 1'b1, 2'd1);
    en1 = 1'b0; clr1 = 1'b1;
    tick(); chk("d1_clr", 1, 32'd0, 1'b0, 2'd0);

    #1;
    if (sb.size() != 0) begin
      n_bad += sb.size();
      $display("FAIL leftover: got %0d unchecked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
